// File: rtl/d_ff.sv
// Parameterised D flip-flop register chain.
// Synchronous active-low reset; q comes straight from the last stage.
module d_ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               STAGES  = 1
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] din
);

    logic [WIDTH-1:0] stage [STAGES];

    // Reset clears the whole chain so no stale data drains out afterwards
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: tb/tb_d_ff.sv
// Bench for d_ff: default 1-bit flop and an 8-bit three-stage chain
// driven in lockstep, checked through a per-edge expectation queue.
module tb_d_ff;

    typedef struct {
        logic       e1;
        logic [7:0] e3;
    } exp_t;

    logic       clk;
    logic       r1;
    logic       d1;
    logic       q1;
    logic       r3;
    logic [7:0] d3;
    logic [7:0] q3;

    exp_t sb[$];
    int   total;
    int   bad;
    logic p1;
    logic [7:0] p3;

    d_ff u1 (
        .q    (q1),
        .clk  (clk),
        .n_rst(r1),
        .din  (d1)
    );

    d_ff #(
        .WIDTH  (8),
        .STAGES (3),
        .RST_VAL(8'hA5)
    ) u3 (
        .q    (q3),
        .clk  (clk),
        .n_rst(r3),
        .din  (d3)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("q1", {7'd0, q1}, {7'd0, e.e1});
            chk("q3", q3, e.e3);
        end
    end

    // One clock cycle: drive inputs, queue the post-edge expectation,
    // optionally probe hold behaviour and inject sub-cycle pulses.
    task automatic cyc(input logic nr1, input logic nd1,
                       input logic nr3, input logic [7:0] nd3,
                       input logic e1, input logic [7:0] e3,
                       input bit h1, input bit h3,
                       input bit glitch, input bit pulse);
        exp_t e;
        r1 = nr1;
        d1 = nd1;
        r3 = nr3;
        d3 = nd3;
        e.e1 = e1;
        e.e3 = e3;
        sb.push_back(e);
        #1;
        if (h1) chk("hold1", {7'd0, q1}, {7'd0, p1});
        if (h3) chk("hold3", q3, p3);
        #1;
        if (glitch) begin
            d1 = ~nd1;
            #1;
            d1 = nd1;
        end
        if (pulse) begin
            r1 = 1'b0;
            #1;
            r1 = 1'b1;
        end
        @(posedge clk);
        p1 = e1;
        p3 = e3;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        p1    = 1'b0;
        p3    = 8'h00;
        r1    = 1'b1;
        d1    = 1'b0;
        r3    = 1'b0;
        d3    = 8'h00;
        //   r1    d1    r3    d3     e1    e3     h1 h3 g  p
        cyc(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'hA5, 0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 8'hA5, 1, 1, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 8'hA5, 1, 1, 0, 0);
        cyc(1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 8'hA5, 1, 1, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 8'hA5, 1, 1, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 8'h01, 1, 1, 1, 0);
        cyc(1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02, 1, 1, 0, 1);
        cyc(1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 8'h03, 1, 1, 0, 0);
        // Reset lands with 04/05 still in flight in the chain
        cyc(1'b1, 1'b1, 1'b0, 8'h06, 1'b1, 8'hA5, 1, 1, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 8'hA5, 1, 1, 0, 0);
        cyc(1'b1, 1'b0, 1'b1, 8'h08, 1'b0, 8'hA5, 1, 1, 1, 0);
        cyc(1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 8'h07, 1, 1, 0, 1);
        cyc(1'b1, 1'b1, 1'b1, 8'h0A, 1'b1, 8'h08, 1, 1, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 8'h0B, 1'b1, 8'h09, 1, 1, 0, 0);
        #2;
        chk("drain", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
